btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 18 +
 rtl/sync_ff.sv | 28 ++
 rtl/btn_debounce.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// a helper that tells whether a state represents a held (debounced-high) button.
package btn_pkg;

  // Debouncer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_e;

  // True in the states where the debounced level is high.
  function automatic logic is_down(input btn_state_e st);
    return (st == PRESSED) || (st == REL_PEND);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input. Reusable for any
// board-level input; STAGES must be at least 2.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage per clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes btn_in, requires DEBOUNCE_CYCLES
// consecutive stable samples before changing the debounced level, and emits
// registered press / release / long-hold pulses.
//
// Handshake: there is none; every output is a free-running registered level
// or single-cycle pulse with no back-pressure.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output btn_state_e state_dbg
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic s;

  btn_state_e        state_q,    state_d;
  logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q,    level_d;
  logic              press_q,    press_d;
  logic              release_q,  release_d;
  logic              long_q,     long_d;

  // Only the synchronizer touches the raw button.
  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (btn_in),
    .q      (s)
  );

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Hold time keeps running through a release bounce; it saturates so the
    // long pulse can only fire on the single 15->16 style step per press.
    if (is_down(state_q)) begin
      if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      if (hold_cnt_q == HOLD_LAST) long_d = 1'b1;
    end

    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d   = PRESS_PEND;
          deb_cnt_d = DEB_ONE;
        end
      end
      PRESS_PEND: begin
        if (!s) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d   = REL_PEND;
          deb_cnt_d = DEB_ONE;
        end
      end
      REL_PEND: begin
        if (s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      default: begin
        state_d   = RELEASED;
        deb_cnt_d = '0;
      end
    endcase

    level_d = is_down(state_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign state_dbg   = state_q;

endmodule
